// File: rtl/clocked_c_pipeline.sv
// clocked_c_pipeline
//   Clocked Muller C-element micropipeline: WIDTH-bit tokens travel through
//   DEPTH stages. Both the producer side (req_i/ack_o) and the consumer side
//   (req_o/ack_i) use two-phase signalling, where each toggle is one event.
//   Stage i holds a token while its phase c[i] differs from c[i+1], so all
//   DEPTH stages can be occupied at once with alternating phases.
//
// Handshake:
//   producer offers a token by toggling req_i while req_i == ack_o, holds
//   data_i until ack_o follows; consumer sees a token while req_o != ack_i,
//   samples data_o, then toggles ack_i to retire it.
//
// Optional build macro: C_PIPE_PROTOCOL_CHECK_EN
//   When defined, a small checker flags handshake violations on err_o,
//   with bit0 for the producer and bit1 for the consumer; both bits are
//   sticky until reset. When undefined, err_o is constant zero.
module clocked_c_pipeline #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ack_o,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [1:0]       err_o
);

  // Phase bits and data registers, one per stage.
  logic [DEPTH-1:0] r_c;
  logic [WIDTH-1:0] r_d [DEPTH];

  // Registered occupancy and flags.
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;

  // Neighbouring phases seen by each stage: c[i-1] and c[i+1], where
  // c[-1] is req_i and c[DEPTH] is ack_i.
  logic [DEPTH-1:0] w_prev;
  logic [DEPTH-1:0] w_next;
  logic [DEPTH-1:0] w_fire;
  logic [DEPTH-1:0] w_c_nxt;
  logic [DEPTH-1:0] w_tok_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_d_src [DEPTH];

  // C-element evaluation: a stage fires when its predecessor carries a new
  // phase and its successor has already consumed the current one. All
  // stages use pre-edge values, so a token moves at most one stage per clock
  // and a stage vacated this edge refills no earlier than the next edge.
  always_comb begin
    w_prev    = {r_c[DEPTH-2:0], req_i};
    w_next    = {ack_i, r_c[DEPTH-1:1]};
    w_fire    = (w_prev ^ r_c) & ~(r_c ^ w_next);
    w_c_nxt   = (r_c & ~w_fire) | (w_prev & w_fire);
    w_tok_nxt = w_c_nxt ^ {ack_i, w_c_nxt[DEPTH-1:1]};
  end

  // Popcount of next-state token occupancy, so the registered count lines
  // up with the phase bits it describes.
  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count_nxt = w_count_nxt + {{(CW-1){1'b0}}, w_tok_nxt[i]};
    end
  end

  // Data source for each stage: the producer for stage 0, the upstream
  // stage register otherwise.
  for (genvar g = 0; g < DEPTH; g++) begin : g_src
    if (g == 0) begin : g_head
      assign w_d_src[g] = data_i;
    end else begin : g_body
      assign w_d_src[g] = r_d[g-1];
    end
  end

  // Phase registers: take the predecessor phase on fire, otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_c <= '0;
    end else begin
      r_c <= w_c_nxt;
    end
  end

  // Data registers: capture alongside the phase bit of the same stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_fire[i]) begin
          r_d[i] <= w_d_src[i];
        end
      end
    end
  end

  // Occupancy count and flags from the next-state phases.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  assign ack_o   = r_c[0];
  assign req_o   = r_c[DEPTH-1];
  assign data_o  = r_d[DEPTH-1];
  assign count_o = r_count;
  assign empty_o = r_empty;
  assign full_o  = r_full;

`ifdef C_PIPE_PROTOCOL_CHECK_EN
  // Previous-cycle copies of the incoming handshake lines.
  logic       r_req_q;
  logic       r_ack_q;
  logic [1:0] r_err;

  // Protocol checker: a producer toggle while the previous offer is still
  // unacknowledged, or a consumer toggle while no token is offered, sets a
  // sticky error bit. The data path never looks at these flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_req_q <= 1'b0;
      r_ack_q <= 1'b0;
      r_err   <= 2'b00;
    end else begin
      r_req_q <= req_i;
      r_ack_q <= ack_i;
      if ((req_i != r_req_q) && (r_req_q != r_c[0])) begin
        r_err[0] <= 1'b1;
      end
      if ((ack_i != r_ack_q) && (r_ack_q == r_c[DEPTH-1])) begin
        r_err[1] <= 1'b1;
      end
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 2'b00;
`endif

endmodule

// File: tb/tb_clocked_c_pipeline.sv
// Testbench for clocked_c_pipeline: a WIDTH=8/DEPTH=3 main instance plus
// WIDTH=32 instances at DEPTH=2 and DEPTH=8 for latency and capacity.
module tb_clocked_c_pipeline;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;

  // Main instance (WIDTH=8, DEPTH=3)
  logic       req_i  = 1'b0;
  logic       ack_i  = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       ack_o, req_o, empty_o, full_o;
  logic [7:0] data_o;
  logic [1:0] count_o;
  logic [1:0] err_o;

  clocked_c_pipeline #(.WIDTH(8), .DEPTH(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .data_i(data_i),
    .ack_o(ack_o), .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .err_o(err_o)
  );

  // Depth-variant instances: index 0 is DEPTH=2, index 1 is DEPTH=8
  logic        x_req  [2];
  logic        x_ack  [2];
  logic [31:0] x_data [2];
  logic        x_ack_o [2];
  logic        x_req_o [2];
  logic        x_empty [2];
  logic        x_full  [2];
  logic [31:0] x_dout  [2];
  logic [1:0]  x_err   [2];
  logic [1:0]  cnt2;
  logic [3:0]  cnt8;
  logic [3:0]  x_cnt   [2];
  assign x_cnt[0] = {2'b00, cnt2};
  assign x_cnt[1] = cnt8;

  clocked_c_pipeline #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .clk(clk), .reset_n(reset_n), .req_i(x_req[0]), .data_i(x_data[0]),
    .ack_o(x_ack_o[0]), .req_o(x_req_o[0]), .data_o(x_dout[0]), .ack_i(x_ack[0]),
    .count_o(cnt2), .empty_o(x_empty[0]), .full_o(x_full[0]), .err_o(x_err[0])
  );

  clocked_c_pipeline #(.WIDTH(32), .DEPTH(8)) u_d8 (
    .clk(clk), .reset_n(reset_n), .req_i(x_req[1]), .data_i(x_data[1]),
    .ack_o(x_ack_o[1]), .req_o(x_req_o[1]), .data_o(x_dout[1]), .ack_i(x_ack[1]),
    .count_o(cnt8), .empty_o(x_empty[1]), .full_o(x_full[1]), .err_o(x_err[1])
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp32_q[$];
  logic        stream_done;

`ifdef C_PIPE_PROTOCOL_CHECK_EN
  localparam logic [1:0] EXP_ERR_PROD = 2'b01;
  localparam logic [1:0] EXP_ERR_BOTH = 2'b11;
`else
  localparam logic [1:0] EXP_ERR_PROD = 2'b00;
  localparam logic [1:0] EXP_ERR_BOTH = 2'b00;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Offer one token once the producer is allowed to toggle.
  task automatic push(input logic [7:0] v);
    int n = 0;
    while (req_i !== ack_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_i !== ack_o) begin
      errors++;
      $display("FAIL push_wait: ack_o=%b, required %b", ack_o, req_i);
    end else begin
      data_i = v;
      req_i  = ~req_i;
      exp_q.push_back(v);
    end
    @(negedge clk);
  endtask

  // Retire one token, comparing it against the scoreboard.
  task automatic pop();
    int n = 0;
    logic [7:0] exp;
    while (req_o === ack_i && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_o === ack_i) begin
      errors++;
      $display("FAIL pop_wait: req_o=%b ack_i=%b, required a pending token", req_o, ack_i);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL pop_extra: token %h delivered, required none", data_o);
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (data_o !== exp) begin
        errors++;
        $display("FAIL pop_data: data_o=%h, required %h", data_o, exp);
      end
      ack_i = ~ack_i;
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    req_i = 1'b0; ack_i = 1'b0; data_i = 8'h00;
    for (int k = 0; k < 2; k++) begin
      x_req[k] = 1'b0; x_ack[k] = 1'b0; x_data[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({count_o, empty_o, full_o, ack_o, req_o, data_o, err_o} !== {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d empty=%b full=%b ack=%b req=%b data=%h err=%b, required 0 1 0 0 0 00 00",
               count_o, empty_o, full_o, ack_o, req_o, data_o, err_o);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    data_i = 8'hA5;
    req_i  = ~req_i;
    exp_q.push_back(8'hA5);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks++;
      if (req_o !== (e == 3)) begin
        errors++;
        $display("FAIL single_req_o edge %0d: req_o=%b, required %b", e, req_o, (e == 3));
      end
      if (e == 1) begin
        checks++;
        if (ack_o !== 1'b1 || count_o !== 2'd1) begin
          errors++;
          $display("FAIL single_accept: ack_o=%b count=%0d, required 1 1", ack_o, count_o);
        end
      end
    end
    checks++;
    if (data_o !== 8'hA5 || count_o !== 2'd1) begin
      errors++;
      $display("FAIL single_out: data_o=%h count=%0d, required a5 1", data_o, count_o);
    end
    pop();
    checks++;
    if (count_o !== 2'd0 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: count=%0d empty=%b, required 0 1", count_o, empty_o);
    end
  endtask

  task automatic test_fill();
    logic a0;
    int   n;
    push(8'h01); push(8'h02); push(8'h03);
    n = 0;
    while (full_o !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (full_o !== 1'b1 || count_o !== 2'd3 || empty_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d empty=%b, required 1 3 0", full_o, count_o, empty_o);
    end
    a0 = ack_o;
    data_i = 8'h04;
    req_i  = ~req_i;
    exp_q.push_back(8'h04);
    repeat (4) @(negedge clk);
    checks++;
    if (ack_o !== a0 || count_o !== 2'd3) begin
      errors++;
      $display("FAIL fill_stall: ack_o=%b count=%0d, required %b 3", ack_o, count_o, a0);
    end
    pop();
    n = 0;
    while (ack_o === a0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ack_o === a0) begin
      errors++;
      $display("FAIL fill_accept: ack_o=%b, required %b", ack_o, ~a0);
    end
    repeat (3) pop();
    repeat (2) @(negedge clk);
    checks++;
    if (empty_o !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fill_drain: empty=%b left=%0d, required 1 0", empty_o, exp_q.size());
    end
  endtask

  task automatic test_stream();
    stream_done = 1'b0;
    fork
      begin
        for (int v = 0; v < 20; v++) push(8'(v));
      end
      begin
        repeat (20) pop();
        stream_done = 1'b1;
      end
      begin
        int n = 0;
        while (!stream_done && n < 2000) begin
          @(posedge clk);
          #1;
          checks++;
          if (count_o > 2'd3 || (full_o === 1'b1) !== (count_o === 2'd3)) begin
            errors++;
            $display("FAIL stream_count: count=%0d full=%b, required count<=3 and full==(count==3)", count_o, full_o);
          end
          n++;
        end
      end
    join
    repeat (2) @(negedge clk);
    checks++;
    if (empty_o !== 1'b1 || exp_q.size() != 0 || err_o !== 2'b00) begin
      errors++;
      $display("FAIL stream_end: empty=%b left=%0d err=%b, required 1 0 00", empty_o, exp_q.size(), err_o);
    end
  endtask

  task automatic test_reset_mid();
    push(8'hAA); push(8'hBB);
    repeat (3) @(negedge clk);
    checks++;
    if (count_o !== 2'd2) begin
      errors++;
      $display("FAIL mid_held: count=%0d, required 2", count_o);
    end
    reset_n = 1'b0;
    req_i = 1'b0;
    ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({count_o, empty_o, full_o, req_o, ack_o, data_o} !== {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset: cnt=%0d empty=%b full=%b req=%b ack=%b data=%h, required 0 1 0 0 0 00",
               count_o, empty_o, full_o, req_o, ack_o, data_o);
    end
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    push(8'h5A);
    pop();
    @(negedge clk);
    checks++;
    if (empty_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: empty=%b, required 1", empty_o);
    end
  endtask

  task automatic test_protocol();
    int n = 0;
    push(8'h11); push(8'h22); push(8'h33);
    while (full_o !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    // Offer a token into the full pipe, then withdraw it by toggling again.
    req_i = ~req_i;
    @(negedge clk);
    req_i = ~req_i;
    @(negedge clk);
    checks++;
    if (err_o !== EXP_ERR_PROD) begin
      errors++;
      $display("FAIL proto_prod: err_o=%b, required %b", err_o, EXP_ERR_PROD);
    end
    repeat (3) pop();
    repeat (2) @(negedge clk);
    checks++;
    if (err_o !== EXP_ERR_PROD || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: err_o=%b empty=%b, required %b 1", err_o, empty_o, EXP_ERR_PROD);
    end
    ack_i = ~ack_i;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (err_o !== EXP_ERR_BOTH) begin
      errors++;
      $display("FAIL proto_cons: err_o=%b, required %b", err_o, EXP_ERR_BOTH);
    end
    reset_n = 1'b0;
    req_i = 1'b0;
    ack_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (err_o !== 2'b00 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL proto_clear: err_o=%b empty=%b, required 00 1", err_o, empty_o);
    end
  endtask

  task automatic test_depth(input int k, input int dep);
    int acc;
    int accepted;
    int n;
    logic [31:0] exp;
    x_data[k] = 32'hDEAD_0000 | 32'(dep);
    x_req[k]  = ~x_req[k];
    exp32_q.push_back(x_data[k]);
    for (int e = 1; e <= dep; e++) begin
      @(negedge clk);
      checks++;
      if (x_req_o[k] !== (e == dep)) begin
        errors++;
        $display("FAIL depth%0d_latency edge %0d: req_o=%b, required %b", dep, e, x_req_o[k], (e == dep));
      end
      if (e == 1) begin
        checks++;
        if (x_ack_o[k] !== 1'b1) begin
          errors++;
          $display("FAIL depth%0d_ack: ack_o=%b, required 1", dep, x_ack_o[k]);
        end
      end
    end
    checks++;
    if (x_dout[k] !== (32'hDEAD_0000 | 32'(dep))) begin
      errors++;
      $display("FAIL depth%0d_data: data_o=%h, required %h", dep, x_dout[k], 32'hDEAD_0000 | 32'(dep));
    end
    // Keep offering tokens with the consumer stalled until the pipe is full.
    acc = 1;
    for (int c = 0; c < 4 * dep + 8; c++) begin
      if (x_req[k] === x_ack_o[k]) begin
        x_data[k] = 32'hC0DE_0000 + 32'(acc);
        x_req[k]  = ~x_req[k];
        exp32_q.push_back(x_data[k]);
        acc++;
      end
      @(negedge clk);
    end
    accepted = acc - ((x_req[k] !== x_ack_o[k]) ? 1 : 0);
    checks++;
    if (accepted != dep || x_cnt[k] !== 4'(dep) || x_full[k] !== 1'b1) begin
      errors++;
      $display("FAIL depth%0d_capacity: accepted=%0d count=%0d full=%b, required %0d %0d 1",
               dep, accepted, x_cnt[k], x_full[k], dep, dep);
    end
    n = 0;
    while (exp32_q.size() != 0 && n < 20 * dep + 40) begin
      if (x_req_o[k] !== x_ack[k]) begin
        exp = exp32_q.pop_front();
        checks++;
        if (x_dout[k] !== exp) begin
          errors++;
          $display("FAIL depth%0d_order: data_o=%h, required %h", dep, x_dout[k], exp);
        end
        x_ack[k] = ~x_ack[k];
      end
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp32_q.size() != 0 || x_empty[k] !== 1'b1 || x_err[k] !== 2'b00) begin
      errors++;
      $display("FAIL depth%0d_drain: left=%0d empty=%b err=%b, required 0 1 00",
               dep, exp32_q.size(), x_empty[k], x_err[k]);
    end
    exp32_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_reset_mid();
    test_protocol();
    test_depth(0, 2);
    test_depth(1, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
